// File: rtl/qdr_dac_serializer.sv
// rtl/qdr_dac_serializer.sv - sample-to-lane DAC serializer with skid buffer and DDR forward clock
//
// Purpose: accepts DATA_W-bit samples over valid/ready and emits each as BEATS
// LANE_W-bit beats on DA. DAFRAME marks the leading FRAME_HI beats and DACLK
// toggles once per beat (clk/2). Frames run back to back while enable is held.
// If no sample is waiting at a frame boundary, the last word (or zero) is
// resent and underrun pulses.
//
// Ports:
//   clk           in   beat clock
//   reset         in   asynchronous reset, active low
//   enable        in   1: start/keep streaming; 0: stop after the current frame
//   data_in       in   [DATA_W-1:0] sample
//   data_valid    in   data_in valid
//   data_ready    out  skid buffer can accept this cycle
//   DA            out  [LANE_W-1:0] serialized beat
//   DAFRAME       out  frame marker
//   DACLK         out  DDR forward clock
//   underrun      out  one-cycle pulse: a frame started with no sample buffered
//   underrun_cnt  out  [15:0] saturating underrun count
module qdr_dac_serializer #(
  parameter int DATA_W        = 14,
  parameter int LANE_W        = 4,
  parameter int FRAME_HI      = ((DATA_W + LANE_W - 1) / LANE_W) / 2,
  parameter int MSB_FIRST     = 1,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [LANE_W-1:0] DA,
  output logic              DAFRAME,
  output logic              DACLK,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int BEATS = (DATA_W + LANE_W - 1) / LANE_W;
  localparam int WW    = BEATS * LANE_W;
  localparam int PAD   = WW - DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [BW-1:0] FRAME_HI_B = BW'(FRAME_HI);

  // DACLK must end each frame low so consecutive frames keep the same phase.
  if (BEATS % 2 != 0) begin : g_beats_check
    $error("qdr_dac_serializer: BEATS=%0d must be even", BEATS);
  end
  if (FRAME_HI < 1 || FRAME_HI > BEATS - 1) begin : g_frame_hi_check
    $error("qdr_dac_serializer: FRAME_HI=%0d out of range 1..%0d", FRAME_HI, BEATS - 1);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] word;
  logic [BW-1:0]     beat;
  logic              under_pend;
  logic              frame_end;
  logic              frame_load;
  logic              accept;

  assign frame_end  = (state == RUN) && (beat == LAST_BEAT);
  assign frame_load = enable && skid_full && ((state == IDLE) || frame_end);
  // The buffer drains into the shift word on frame_load, so it can take a new
  // sample in that same cycle.
  assign data_ready = !skid_full || frame_load;
  assign accept     = data_valid && data_ready;

  function automatic logic [LANE_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                 input logic [BW-1:0]     b);
    logic [WW-1:0]     padded;
    logic [BW-1:0]     idx;
    logic [LANE_W-1:0] s;
    padded = WW'(w) << PAD;
    idx    = (MSB_FIRST != 0) ? (LAST_BEAT - b) : b;
    s      = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (idx == BW'(k)) s = padded[k*LANE_W +: LANE_W];
    end
    return s;
  endfunction

  // Outputs are registered from the sequencer state, so DA trails the beat
  // counter by one cycle. The underrun pulse and count are delayed by one
  // cycle through under_pend, which lines them up with beat 0 of the refilled
  // frame on DA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      skid_full    <= 1'b0;
      skid_data    <= '0;
      word         <= '0;
      beat         <= '0;
      under_pend   <= 1'b0;
      DA           <= '0;
      DAFRAME      <= 1'b0;
      DACLK        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (frame_load) begin
        skid_full <= accept;
        if (accept) skid_data <= data_in;
      end else if (accept) begin
        skid_full <= 1'b1;
        skid_data <= data_in;
      end

      underrun   <= under_pend;
      under_pend <= 1'b0;
      if (under_pend && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;

      case (state)
        IDLE: begin
          DA      <= '0;
          DAFRAME <= 1'b0;
          DACLK   <= 1'b0;
          if (frame_load) begin
            word  <= skid_data;
            beat  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          DA      <= slice_of(word, beat);
          DAFRAME <= (beat < FRAME_HI_B);
          DACLK   <= ~beat[0];
          if (frame_end) begin
            beat <= '0;
            if (!enable) begin
              state <= IDLE;
            end else if (skid_full) begin
              word <= skid_data;
            end else begin
              under_pend <= 1'b1;
              if (UNDERRUN_ZERO != 0) word <= '0;
            end
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdr_dac_serializer.sv
// tb/tb_qdr_dac_serializer.sv - self-checking bench for qdr_dac_serializer
module tb_qdr_dac_serializer;

  logic        clk;
  logic        reset;
  logic        a_en, a_valid, a_ready, a_frame, a_dclk, a_under;
  logic [13:0] a_data;
  logic [3:0]  a_da;
  logic [15:0] a_cnt;
  logic        b_en, b_valid, b_ready, b_frame, b_dclk, b_under;
  logic [15:0] b_data;
  logic [3:0]  b_da;
  logic [15:0] b_cnt;

  int          total;
  int          bad;
  logic [13:0] tx_q[$];
  logic [13:0] w[4];
  logic [15:0] rb;
  int          n;

  qdr_dac_serializer dut (
    .clk(clk), .reset(reset), .enable(a_en), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .DA(a_da), .DAFRAME(a_frame), .DACLK(a_dclk),
    .underrun(a_under), .underrun_cnt(a_cnt)
  );

  qdr_dac_serializer #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(0), .UNDERRUN_ZERO(1)) dut16 (
    .clk(clk), .reset(reset), .enable(b_en), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .DA(b_da), .DAFRAME(b_frame), .DACLK(b_dclk),
    .underrun(b_under), .underrun_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference nibble: pad the sample to 16 bits at the bottom, cut into
  // nibbles, and pick the nibble for beat b in the configured order.
  function automatic logic [3:0] exp_nib(input bit sel, input logic [15:0] word, input int b);
    int unsigned padded;
    int unsigned k;
    if (sel) begin
      padded = word;
      k = b;
    end else begin
      padded = (word & 16'h3FFF) * 4;
      k = 3 - b;
    end
    return 4'((padded >> (4 * k)) & 15);
  endfunction

  // One clock; the queued word on port a is retired when the edge took it.
  task automatic step();
    logic acc;
    acc = a_valid && a_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(tx_q.pop_front());
      if (tx_q.size() > 0) a_data = tx_q[0];
      else a_valid = 1'b0;
    end
  endtask

  task automatic start_tx();
    if (tx_q.size() > 0) begin
      a_data  = tx_q[0];
      a_valid = 1'b1;
    end
  endtask

  task automatic check_frame(input bit sel, input logic [15:0] word, input bit exp_under,
                             input int exp_cnt, input int drop_b, input string tag);
    for (int b = 0; b < 4; b++) begin
      step();
      chk({tag, "_da"},    sel ? b_da    : a_da,    exp_nib(sel, word, b));
      chk({tag, "_frame"}, sel ? b_frame : a_frame, (b < 2) ? 1 : 0);
      chk({tag, "_daclk"}, sel ? b_dclk  : a_dclk,  (b % 2 == 0) ? 1 : 0);
      chk({tag, "_under"}, sel ? b_under : a_under, (b == 0 && exp_under) ? 1 : 0);
      chk({tag, "_cnt"},   sel ? b_cnt   : a_cnt,   exp_cnt);
      if (b == drop_b) begin
        if (sel) b_en = 1'b0;
        else a_en = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input bit sel, input int cycles, input int exp_cnt, input string tag);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk({tag, "_da"},    sel ? b_da    : a_da,    0);
      chk({tag, "_frame"}, sel ? b_frame : a_frame, 0);
      chk({tag, "_daclk"}, sel ? b_dclk  : a_dclk,  0);
      chk({tag, "_under"}, sel ? b_under : a_under, 0);
      chk({tag, "_cnt"},   sel ? b_cnt   : a_cnt,   exp_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    a_en = 1'b0; a_valid = 1'b0; a_data = '0;
    b_en = 1'b0; b_valid = 1'b0; b_data = '0;

    #12;
    chk("rst_da", a_da, 0);
    chk("rst_frame", a_frame, 0);
    chk("rst_daclk", a_dclk, 0);
    chk("rst_under", a_under, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_b_da", b_da, 0);
    chk("rst_b_cnt", b_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("ready_after_reset", a_ready, 1);

    // Single word, then starve the buffer: repeats with underrun, then stop.
    a_en = 1'b1;
    tx_q.push_back(14'h2A5C);
    start_tx();
    step();
    step();
    check_frame(0, 16'h2A5C, 0, 0, -1, "t1");
    check_frame(0, 16'h2A5C, 1, 1, -1, "t3a");
    check_frame(0, 16'h2A5C, 1, 2, 1, "t3b");
    check_idle(0, 3, 2, "t4_idle");

    // Back-to-back pair with valid held.
    a_en = 1'b1;
    tx_q.push_back(14'h3FFF);
    tx_q.push_back(14'h0001);
    start_tx();
    chk("t2_ready0", a_ready, 1);
    step();
    chk("t2_ready1", a_ready, 1);
    step();
    check_frame(0, 16'h3FFF, 0, 2, -1, "t2a");
    check_frame(0, 16'h0001, 0, 2, 1, "t2b");
    check_idle(0, 2, 2, "t2_idle");

    // Random gap-free streams of 2..4 words.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) begin
        w[i] = 14'($urandom);
        tx_q.push_back(w[i]);
      end
      a_en = 1'b1;
      start_tx();
      step();
      step();
      for (int i = 0; i < n; i++) check_frame(0, {2'b00, w[i]}, 0, 2, (i == n - 1) ? 1 : -1, "rnd");
      check_idle(0, 2, 2, "rnd_idle");
    end

    // Asynchronous reset mid-frame with a second word sitting in the buffer.
    a_en = 1'b1;
    w[0] = 14'($urandom);
    w[1] = 14'($urandom);
    tx_q.push_back(w[0]);
    tx_q.push_back(w[1]);
    start_tx();
    for (int i = 0; i < 5; i++) step();
    chk("t5_beat2_da", a_da, exp_nib(0, {2'b00, w[0]}, 2));
    chk("t5_beat2_daclk", a_dclk, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_da", a_da, 0);
    chk("t5_frame", a_frame, 0);
    chk("t5_daclk", a_dclk, 0);
    chk("t5_under", a_under, 0);
    chk("t5_cnt", a_cnt, 0);
    chk("t5_ready", a_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_idle(0, 5, 0, "t5_empty");
    a_en = 1'b0;

    // 16-bit, LSB-first, zero-fill instance.
    b_en = 1'b1;
    b_data = 16'h1234;
    b_valid = 1'b1;
    chk("t6_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    step();
    check_frame(1, 16'h1234, 0, 0, -1, "t6");
    check_frame(1, 16'h0000, 1, 1, -1, "t6_uz1");
    check_frame(1, 16'h0000, 1, 2, 1, "t6_uz2");
    check_idle(1, 2, 2, "t6_idle");
    rb = 16'($urandom);
    b_en = 1'b1;
    b_data = rb;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    check_frame(1, rb, 0, 2, 1, "t6_rnd");
    check_idle(1, 2, 2, "t6_rnd_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
